// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
// Shared types and line-level constants for the FIFO-draining UART
// transmitter. Imported by fifo_uart_tx.
//   tx_state_t : transmitter FSM states
//   LINE_IDLE  : level of the serial line when nothing is being sent
//   START_LVL  : level of the start bit
//   STOP_LVL   : level of the stop bit
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter
// Divides clk down to serial bit periods. Counts 0..CLKS_PER_BIT-1 and
// wraps to 0 at the end of every bit period.
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous, active-high
//   clear   : synchronous restart of the count at 0 (held while no frame runs)
//   bit_end : high in the last cycle of each bit period
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running bit-period counter; clear forces the first cycle of the
  // next bit period so a frame always starts on a full-length start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Decoded from the registered count, so it is glitch-free relative to clk.
  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drains a byte FIFO onto an 8N1 serial line. Whenever the FIFO is
// non-empty one byte is popped and sent as start bit, DATA_WIDTH data bits
// LSB first, stop bit. Frames run back-to-back while data remains, with
// exactly two idle-high cycles (FETCH, LOAD) between them.
// Parameters:
//   DATA_WIDTH   : byte width, must match the FIFO data width
//   CLKS_PER_BIT : clk cycles per serial bit, must be >= 2
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous, active-high, shared with the FIFO
//   empty   : FIFO empty flag
//   data_in : FIFO data_out, valid the cycle after rd was sampled
//   rd      : FIFO read strobe, one cycle per byte
//   tx      : serial line, idles high
//   busy    : high whenever the FSM is not in IDLE
//   done    : one-cycle pulse in the last cycle of each stop bit
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  bit_end;
  logic                  baud_clear;

  // The baud counter is held at 0 outside START/DATA/STOP so the start bit
  // always lasts a full CLKS_PER_BIT cycles after LOAD.
  assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  // done is a decode of the registered state and registered baud count, so
  // it lands exactly in the final stop-bit cycle without a look-ahead term.
  assign done = (state == STOP) && bit_end;

  // Transmit FSM. tx, rd and busy are registered alongside the state: each
  // transition loads the value the output must show in the new state, so no
  // output ever depends combinationally on empty. empty is only looked at in
  // IDLE and on the final stop-bit cycle; rd is therefore only raised after
  // a sample that saw the FIFO non-empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= LINE_IDLE;
      rd      <= 1'b0;
      busy    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      rd <= 1'b0;
      case (state)
        IDLE: begin
          tx <= LINE_IDLE;
          if (!empty) begin
            state <= FETCH;
            rd    <= 1'b1;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg   <= data_in;
          bit_cnt <= '0;
          tx      <= START_LVL;
          state   <= START;
        end
        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              tx    <= STOP_LVL;
              state <= STOP;
            end else begin
              tx <= shreg[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!empty) begin
              state <= FETCH;
              rd    <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= LINE_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 (40-cycle frames).
// A small byte-FIFO model sits in front of the DUT; its empty flag can be
// overridden to exercise glitches on empty while a frame is in flight.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       empty;
  logic [7:0] fifoDataOut;
  logic       rd;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] fifoMem [64];
  int         pushCount      = 0;
  int         popCount       = 0;
  int         rdPulses       = 0;
  int         underflowCount = 0;
  int         cycleCount     = 0;
  logic       overrideOn     = 1'b0;
  logic       overrideVal    = 1'b0;
  logic       fifoEmpty;

  int checkCount = 0;
  int errorCount = 0;

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .empty  (empty),
    .data_in(fifoDataOut),
    .rd     (rd),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  assign fifoEmpty = (pushCount == popCount);
  assign empty     = overrideOn ? overrideVal : fifoEmpty;

  // FIFO model: a strobe sampled at an edge presents the popped byte after
  // that edge. Reset discards everything still queued.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      popCount    <= pushCount;
      fifoDataOut <= '0;
    end else if (rd && !fifoEmpty) begin
      fifoDataOut <= fifoMem[popCount[5:0]];
      popCount    <= popCount + 1;
    end
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  always @(posedge clk) begin
    if (rd) rdPulses <= rdPulses + 1;
  end

  always @(negedge clk) begin
    if (rd && empty) underflowCount <= underflowCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifoMem[pushCount[5:0]] = b;
    pushCount = pushCount + 1;
  endtask

  task automatic waitRd(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!rd && waited < budget);
    checkOutput("rdSeen", {31'd0, rd}, 32'd1);
  endtask

  // Called at the negedge of the FETCH cycle; walks LOAD and the whole
  // frame, checking every cycle against the expected 8N1 waveform.
  task automatic checkFrame(input logic [7:0] b, input bit toggleEmpty);
    logic [7:0] decoded;
    logic       expTx;
    int         bitIdx;
    checkOutput($sformatf("fetch_%02h", b), {29'd0, tx, busy, rd}, 32'b111);
    @(negedge clk);
    checkOutput($sformatf("load_%02h", b), {29'd0, tx, busy, rd}, 32'b110);
    decoded = '0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k < CPB) begin
        expTx = 1'b0;
      end else if (k < 9 * CPB) begin
        bitIdx = (k - CPB) / CPB;
        expTx  = b[bitIdx];
        if ((k % CPB) == CPB / 2) decoded[bitIdx] = tx;
      end else begin
        expTx = 1'b1;
      end
      checkOutput($sformatf("frame_%02h_k%0d", b, k), {28'd0, tx, done, busy, rd},
                  {28'd0, expTx, (k == FRAME - 1), 1'b1, 1'b0});
      if (toggleEmpty) begin
        if (k < 9 * CPB) begin
          overrideOn  = 1'b1;
          overrideVal = 1'($urandom_range(1, 0));
        end else begin
          overrideOn = 1'b0;
        end
      end
    end
    checkOutput($sformatf("decoded_%02h", b), {24'd0, decoded}, {24'd0, b});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         w;
    int         c0;
    int         r0;
    logic [7:0] burst [8];
    burst = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h7E, 8'h81};

    // Reset and long idle with the FIFO empty
    #1 reset = 1'b1;
    #1 checkOutput("resetAsync", {28'd0, tx, done, busy, rd}, 32'b1000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("idleEmpty", {28'd0, tx, done, busy, rd}, 32'b1000);
    end

    // Single byte 100
    $display("[TB] single byte");
    applyStimulus(8'd100);
    waitRd(10, w);
    checkOutput("rdLatency", w, 1);
    checkFrame(8'd100, 1'b0);
    @(negedge clk);
    checkOutput("afterSingle", {28'd0, tx, done, busy, rd}, 32'b1000);
    checkOutput("singleRdPulses", rdPulses, 1);

    // Three preloaded bytes back-to-back
    $display("[TB] back-to-back");
    applyStimulus(8'd100);
    applyStimulus(8'd150);
    applyStimulus(8'd200);
    waitRd(10, w);
    c0 = cycleCount;
    checkFrame(8'd100, 1'b0);
    waitRd(3, w);
    checkOutput("gap1", cycleCount - c0, 42);
    c0 = cycleCount;
    checkFrame(8'd150, 1'b0);
    waitRd(3, w);
    checkOutput("gap2", cycleCount - c0, 42);
    checkFrame(8'd200, 1'b0);
    @(negedge clk);
    checkOutput("afterThree", {28'd0, tx, done, busy, rd}, 32'b1000);
    checkOutput("drainedThree", {31'd0, fifoEmpty}, 32'd1);
    checkOutput("threeRdPulses", rdPulses, 4);

    // empty glitching during a frame with one byte queued behind it
    $display("[TB] empty toggling");
    applyStimulus(8'hA5);
    applyStimulus(8'h3C);
    waitRd(10, w);
    checkFrame(8'hA5, 1'b1);
    overrideOn = 1'b0;
    waitRd(3, w);
    checkOutput("gapToggle", w, 1);
    checkFrame(8'h3C, 1'b0);
    @(negedge clk);
    checkOutput("afterToggle", {28'd0, tx, done, busy, rd}, 32'b1000);

    // Reset in bit 3 of a frame, then a clean frame of 15
    $display("[TB] mid-frame reset");
    applyStimulus(8'hF0);
    waitRd(10, w);
    repeat (1 + CPB + 3 * CPB + 2) @(negedge clk);
    checkOutput("bit3Low", {30'd0, tx, busy}, 32'b01);
    #2 reset = 1'b1;
    #1 checkOutput("midReset", {28'd0, tx, done, busy, rd}, 32'b1000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(8'd15);
    waitRd(10, w);
    checkOutput("rdLatencyAfterReset", w, 1);
    checkFrame(8'd15, 1'b0);
    @(negedge clk);
    checkOutput("afterReset15", {28'd0, tx, done, busy, rd}, 32'b1000);

    // Eight bytes written while the block drains
    $display("[TB] concurrent fill");
    r0 = rdPulses;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          repeat (17) @(negedge clk);
          applyStimulus(burst[i]);
        end
      end
      begin
        for (int j = 0; j < 8; j++) begin
          waitRd(200, w);
          checkFrame(burst[j], 1'b0);
        end
      end
    join
    @(negedge clk);
    checkOutput("afterBurst", {28'd0, tx, done, busy, rd}, 32'b1000);
    checkOutput("drainedBurst", {31'd0, fifoEmpty}, 32'd1);
    checkOutput("burstRdPulses", rdPulses - r0, 8);
    checkOutput("underflow", underflowCount, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit drain for the byte FIFO. Whenever the FIFO reports non-empty, the block pops one byte and shifts it out as an 8N1 UART frame: start bit, 8 data bits LSB first, stop bit. It sits directly downstream of the FIFO, driving its `rd` and consuming its `data_out` and `empty`. The line idles high and frames are sent back-to-back while data remains.

## Interface
- `DATA_WIDTH`, 8: byte width. It must match the FIFO data width.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit. Must be ≥2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high. Shared with the FIFO.
- `empty` in 1: FIFO empty flag.
- `data_in` in DATA_WIDTH: FIFO `data_out`.
- `rd` out 1: FIFO read strobe. High for exactly one cycle per byte.
- `tx` out 1: serial line. Idle high.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse in the last cycle of each stop bit.

## Operation
- FIFO contract: a read strobe sampled high at edge N makes the popped byte valid on `data_out` after edge N. This block captures it one cycle later.
- States:
  - IDLE: `tx`=1. Go to FETCH when `empty`=0, otherwise stay.
  - FETCH: exactly 1 cycle. `rd`=1, `tx`=1. Always go to LOAD.
  - LOAD: exactly 1 cycle. `tx`=1. `shreg` ← `data_in`, bit counter ← 0, baud counter ← 0. Go to START.
  - START: CLKS_PER_BIT cycles with `tx`=0. Go to DATA.
  - DATA: 8 bit periods of CLKS_PER_BIT cycles each, with `tx`=`shreg[0]`. At the end of each period, `shreg` shifts right and the bit counter increments. After bit 7, go to STOP.
  - STOP: CLKS_PER_BIT cycles with `tx`=1 and `done`=1 in the final cycle. On exit, go to FETCH if `empty`=0, otherwise go to IDLE.
- `rd` and `tx` are decoded from registered state/shift bits. Neither passes through combinational logic from `empty`.
- `empty` is sampled only in IDLE and in the last cycle of STOP. Changes at any other time have no effect on the frame in progress.
- `rd` is never asserted while `empty`=1 at the sampling point, so the block never underflows the FIFO.
- Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..CLKS_PER_BIT−1 and wraps to 0 at each bit boundary.
- Bit counter is 3 bits wide (`$clog2(DATA_WIDTH)`).

## Timing
- Reset values: state=IDLE, `tx`=1, `rd`=0, `busy`=0, `done`=0, `shreg`=0, counters=0. Outputs take these values immediately on `reset` assertion, not on the next edge.
- Reset mid-frame aborts the frame:
  - `tx` returns high asynchronously and the partial byte is lost.
  - The FIFO is reset by the same line, so no resynchronisation is required.
- Latency from `empty` falling in IDLE:
  - `rd` high in cycle +1.
  - Start bit begins in cycle +3.
- Frame length from first START cycle to last STOP cycle: 10·CLKS_PER_BIT cycles.
- Back-to-back period with a continuously non-empty FIFO: `rd` pulses are 10·CLKS_PER_BIT+2 cycles apart. `tx` stays high for exactly 2 cycles (FETCH, LOAD) between frames.
- `busy` rises in the FETCH cycle. It falls only when the block returns to IDLE.

## Structure
- Package `fifo_uart_pkg`:
  - state enum `tx_state_t` {IDLE, FETCH, LOAD, START, DATA, STOP}.
  - constants `LINE_IDLE`=1, `START_LVL`=0, `STOP_LVL`=1.
- Sub-module `uart_baud_counter`:
  - Parameter: CLKS_PER_BIT.
  - Inputs: `clk`, `reset`, `clear`.
  - Output: `bit_end`, high in the last cycle of each bit period.
- The top level holds the FSM, shift register and bit counter.

## Test plan
All scenarios use CLKS_PER_BIT=4, i.e. 40-cycle frames.
- Reset, then `empty` held 1 for 100 cycles → `tx`=1, `rd`=0, `busy`=0 throughout.
- Single byte 8'd100 (0x64) → exactly one `rd` pulse. `tx` shows 0 | 0,0,1,0,0,1,1,0 | 1, each level held 4 cycles. One `done` pulse in the 40th frame cycle.
- FIFO preloaded with 100, 150, 200 → three `rd` pulses spaced 42 cycles apart with `tx` high for 2 cycles between frames. Decoded bytes are 100, 150, 200. `busy` stays high until after the third stop bit.
- `empty` toggled randomly during DATA of a frame with one byte queued → current frame unchanged. The next `rd` comes only after the STOP end with `empty`=0.
- `reset` asserted in bit 3 of a frame → `tx`=1 and `busy`=0 in the same cycle. After release with 8'd15 written, a clean frame 0 | 1,1,1,1,0,0,0,0 | 1 is sent.
- FIFO written with 8 bytes while the block drains → the bytes are emitted in order with no `rd` while `empty`=1, and the FIFO ends empty.
